// File: rtl/ds_operand_stage_pkg.sv
// Shared decode-stage definitions: opcode/funct constants,
// register-address width and producer-bus field layout.
package ds_operand_stage_pkg;

  localparam int REG_ADDR_W = 5;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef struct packed {
    logic rs;
    logic rt;
  } src_need_t;

  function automatic int waddr_lsb(input int stage);
    return stage * REG_ADDR_W;
  endfunction

endpackage

// File: rtl/ds_operand_stage_src_need_decode.sv
// Decodes which source registers an instruction reads.
// Unknown encodings read neither operand.
module src_need_decode
  import ds_operand_stage_pkg::*;
(
  input  logic [31:0] inst_i,
  output src_need_t   need_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       sp;
  logic       alu3;
  logic       shft;
  logic       jr;
  logic       imm;
  logic       stbr;

  assign op = inst_i[OP_LSB +: 6];
  assign fn = inst_i[5:0];
  assign sp = (op == OP_SPECIAL);

  assign alu3 = sp && (fn inside {FN_ADDU, FN_SUBU,
                                  FN_SLT, FN_SLTU,
                                  FN_AND, FN_OR,
                                  FN_XOR, FN_NOR});
  assign shft = sp && (fn inside {FN_SLL, FN_SRL,
                                  FN_SRA});
  assign jr   = sp && (fn == FN_JR);
  assign imm  = (op inside {OP_ADDIU, OP_LW});
  assign stbr = (op inside {OP_SW, OP_BEQ, OP_BNE});

  always_comb begin
    need_o = '0;
    unique case (1'b1)
      alu3:    need_o = '{rs: 1'b1, rt: 1'b1};
      stbr:    need_o = '{rs: 1'b1, rt: 1'b1};
      shft:    need_o = '{rs: 1'b0, rt: 1'b1};
      jr:      need_o = '{rs: 1'b1, rt: 1'b0};
      imm:     need_o = '{rs: 1'b1, rt: 1'b0};
      default: need_o = '0;
    endcase
  end

endmodule

// File: rtl/ds_operand_stage.sv
// Decode-stage operand unit: pipeline register, RAW
// bypass/interlock, EX handshake, hazard-stall counter.
module ds_operand_stage
  import ds_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NSTAGE = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fs_to_ds_valid,
  input  logic [31:0]                  fs_inst,
  input  logic [31:0]                  fs_pc,
  output logic                         ds_allowin,
  input  logic                         es_allowin,
  input  logic                         ds_flush,
  output logic                         ds_valid,
  output logic                         ds_to_es_valid,
  output logic [31:0]                  ds_inst,
  output logic [31:0]                  ds_pc,
  output logic [REG_ADDR_W-1:0]        rf_raddr1,
  output logic [REG_ADDR_W-1:0]        rf_raddr2,
  input  logic [DATA_W-1:0]            rf_rdata1,
  input  logic [DATA_W-1:0]            rf_rdata2,
  input  logic [NSTAGE-1:0]            prod_valid,
  input  logic [NSTAGE-1:0]            prod_we,
  input  logic [REG_ADDR_W*NSTAGE-1:0] prod_waddr,
  input  logic [DATA_W*NSTAGE-1:0]     prod_wdata,
  input  logic [NSTAGE-1:0]            prod_rdy,
  output logic [DATA_W-1:0]            rs_value,
  output logic [DATA_W-1:0]            rt_value,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam bit FWD = (FWD_EN != 0);

  logic                  valid_q, valid_d;
  logic [31:0]           inst_q, inst_d;
  logic [31:0]           pc_q, pc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  src_need_t             need;
  logic [REG_ADDR_W-1:0] rs, rt;
  logic [NSTAGE-1:0]     m_rs, m_rt;
  logic                  hit_rs, hit_rt;
  logic                  rdy_rs, rdy_rt;
  logic [DATA_W-1:0]     fwd_rs, fwd_rt;
  logic                  stl_rs, stl_rt;
  logic                  hazard;

  src_need_decode u_need (
    .inst_i (inst_q),
    .need_o (need)
  );

  assign rs = inst_q[RS_LSB +: REG_ADDR_W];
  assign rt = inst_q[RT_LSB +: REG_ADDR_W];

  for (genvar g = 0; g < NSTAGE; g++) begin : g_match
    logic [REG_ADDR_W-1:0] wa;
    logic                  wr;
    assign wa = prod_waddr[waddr_lsb(g) +: REG_ADDR_W];
    assign wr = prod_valid[g] && prod_we[g];
    assign m_rs[g] = need.rs && (rs != '0) && wr && (wa == rs);
    assign m_rt[g] = need.rt && (rt != '0) && wr && (wa == rt);
  end

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    hit_rs = 1'b0;
    rdy_rs = 1'b0;
    fwd_rs = '0;
    hit_rt = 1'b0;
    rdy_rt = 1'b0;
    fwd_rt = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (m_rs[i]) begin
        hit_rs = 1'b1;
        rdy_rs = prod_rdy[i];
        fwd_rs = prod_wdata[i*DATA_W +: DATA_W];
      end
      if (m_rt[i]) begin
        hit_rt = 1'b1;
        rdy_rt = prod_rdy[i];
        fwd_rt = prod_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign stl_rs = hit_rs && !(FWD && rdy_rs);
  assign stl_rt = hit_rt && !(FWD && rdy_rt);
  assign hazard = stl_rs || stl_rt;

  assign rs_value = (FWD && hit_rs && rdy_rs) ? fwd_rs
                                              : rf_rdata1;
  assign rt_value = (FWD && hit_rt && rdy_rt) ? fwd_rt
                                              : rf_rdata2;

  assign ds_to_es_valid = !reset && valid_q && !hazard
                          && !ds_flush;
  assign ds_allowin     = reset || !valid_q
                          || (!hazard && es_allowin);

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (valid_q && hazard && !ds_flush && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
    if (ds_flush) begin
      valid_d = 1'b0;
    end else if (ds_allowin) begin
      valid_d = fs_to_ds_valid;
      if (fs_to_ds_valid) begin
        inst_d = fs_inst;
        pc_d   = fs_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ds_valid  = valid_q;
  assign ds_inst   = inst_q;
  assign ds_pc     = pc_q;
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ds_operand_stage.sv
// Randomized scoreboard bench: a bypassing unit (2-bit counter)
// and an interlocking unit share one stimulus stream.
module tb_ds_operand_stage;

  localparam int NS = 3;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          fs_v = 1'b0;
  logic [31:0]   fs_inst = '0;
  logic [31:0]   fs_pc = '0;
  logic          es_allowin = 1'b1;
  logic          flush = 1'b0;
  logic [NS-1:0] p_valid = '0;
  logic [NS-1:0] p_we = '0;
  logic [NS-1:0] p_rdy = '0;
  logic [5*NS-1:0]  p_waddr = '0;
  logic [32*NS-1:0] p_wdata = '0;
  logic [31:0]   regs [32];

  logic        a_allow [2];
  logic        a_valid [2];
  logic        a_toes  [2];
  logic [31:0] a_inst  [2];
  logic [31:0] a_pc    [2];
  logic [31:0] a_rs    [2];
  logic [31:0] a_rt    [2];
  logic [31:0] a_cnt   [2];
  logic [4:0]  ra1     [2];
  logic [4:0]  ra2     [2];
  logic [1:0]  cnt_f;

  assign a_cnt[0] = {30'b0, cnt_f};

  ds_operand_stage #(
    .DATA_W(32), .NSTAGE(NS), .FWD_EN(1), .CNT_W(2)
  ) u_fwd (
    .clk(clk), .reset(reset),
    .fs_to_ds_valid(fs_v), .fs_inst(fs_inst), .fs_pc(fs_pc),
    .ds_allowin(a_allow[0]), .es_allowin(es_allowin),
    .ds_flush(flush), .ds_valid(a_valid[0]),
    .ds_to_es_valid(a_toes[0]),
    .ds_inst(a_inst[0]), .ds_pc(a_pc[0]),
    .rf_raddr1(ra1[0]), .rf_raddr2(ra2[0]),
    .rf_rdata1(regs[ra1[0]]), .rf_rdata2(regs[ra2[0]]),
    .prod_valid(p_valid), .prod_we(p_we),
    .prod_waddr(p_waddr), .prod_wdata(p_wdata),
    .prod_rdy(p_rdy),
    .rs_value(a_rs[0]), .rt_value(a_rt[0]),
    .stall_cnt(cnt_f)
  );

  ds_operand_stage #(
    .DATA_W(32), .NSTAGE(NS), .FWD_EN(0), .CNT_W(32)
  ) u_ilk (
    .clk(clk), .reset(reset),
    .fs_to_ds_valid(fs_v), .fs_inst(fs_inst), .fs_pc(fs_pc),
    .ds_allowin(a_allow[1]), .es_allowin(es_allowin),
    .ds_flush(flush), .ds_valid(a_valid[1]),
    .ds_to_es_valid(a_toes[1]),
    .ds_inst(a_inst[1]), .ds_pc(a_pc[1]),
    .rf_raddr1(ra1[1]), .rf_raddr2(ra2[1]),
    .rf_rdata1(regs[ra1[1]]), .rf_rdata2(regs[ra2[1]]),
    .prod_valid(p_valid), .prod_we(p_we),
    .prod_waddr(p_waddr), .prod_wdata(p_wdata),
    .prod_rdy(p_rdy),
    .rs_value(a_rs[1]), .rt_value(a_rt[1]),
    .stall_cnt(a_cnt[1])
  );

  // {op, funct, need_rs, need_rt}; op != 0 means I-type
  logic [13:0] tbl [19];
  initial begin
    tbl[0]  = {6'h00, 6'h21, 2'b11};
    tbl[1]  = {6'h00, 6'h23, 2'b11};
    tbl[2]  = {6'h00, 6'h2a, 2'b11};
    tbl[3]  = {6'h00, 6'h2b, 2'b11};
    tbl[4]  = {6'h00, 6'h24, 2'b11};
    tbl[5]  = {6'h00, 6'h25, 2'b11};
    tbl[6]  = {6'h00, 6'h26, 2'b11};
    tbl[7]  = {6'h00, 6'h27, 2'b11};
    tbl[8]  = {6'h00, 6'h00, 2'b01};
    tbl[9]  = {6'h00, 6'h02, 2'b01};
    tbl[10] = {6'h00, 6'h03, 2'b01};
    tbl[11] = {6'h00, 6'h08, 2'b10};
    tbl[12] = {6'h09, 6'h00, 2'b10};
    tbl[13] = {6'h23, 6'h00, 2'b10};
    tbl[14] = {6'h2b, 6'h00, 2'b11};
    tbl[15] = {6'h04, 6'h00, 2'b11};
    tbl[16] = {6'h05, 6'h00, 2'b11};
    tbl[17] = {6'h3f, 6'h00, 2'b00};
    tbl[18] = {6'h00, 6'h3f, 2'b00};
  end

  function automatic logic [1:0] need_of(input logic [31:0] ins);
    logic [13:0] t;
    for (int k = 0; k < 19; k++) begin
      t = tbl[k];
      if (t[13:8] == ins[31:26] &&
          (t[13:8] != 6'h00 || t[7:2] == ins[5:0]))
        return t[1:0];
    end
    return 2'b00;
  endfunction

  function automatic logic [31:0] make_inst();
    logic [13:0] t;
    logic [4:0]  s, d, r;
    t = tbl[$urandom_range(0, 18)];
    s = 5'($urandom % 8);
    d = 5'($urandom % 8);
    r = 5'($urandom % 8);
    if (t[13:8] != 6'h00)
      return {t[13:8], s, d, 16'($urandom)};
    return {6'h00, s, d, r, 5'($urandom), t[7:2]};
  endfunction

  typedef struct {
    bit          toes;
    bit          allow;
    bit          valid;
    logic [31:0] cnt, inst, pc, rs, rt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic        m_valid [2];
  logic [31:0] m_inst  [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_cnt   [2];
  logic [31:0] m_max   [2];

  int errors = 0;
  int checks = 0;

  // Youngest matching producer decides; $0 and unused fields never match.
  task automatic resolve(input int u, input bit need,
                         input logic [4:0] r,
                         output bit st, output logic [31:0] v);
    v  = regs[r];
    st = 1'b0;
    if (need && r != 5'd0) begin
      for (int i = 0; i < NS; i++) begin
        if (p_valid[i] && p_we[i] && p_waddr[5*i +: 5] == r) begin
          if (u == 0 && p_rdy[i]) v = p_wdata[32*i +: 32];
          else st = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      exp_t        e;
      bit          s1, s2, hz;
      logic [31:0] v1, v2, ins;
      logic [1:0]  nd;
      ins = m_inst[u];
      nd  = need_of(ins);
      resolve(u, nd[1], ins[25:21], s1, v1);
      resolve(u, nd[0], ins[20:16], s2, v2);
      hz = s1 || s2;
      e.valid = m_valid[u];
      e.cnt   = m_cnt[u];
      e.inst  = ins;
      e.pc    = m_pc[u];
      e.rs    = v1;
      e.rt    = v2;
      e.toes  = !reset && m_valid[u] && !hz && !flush;
      e.allow = reset || !m_valid[u] || (!hz && es_allowin);
      if (u == 0) q0.push_back(e);
      else q1.push_back(e);
      if (reset) begin
        m_valid[u] = 1'b0;
        m_inst[u]  = '0;
        m_pc[u]    = '0;
        m_cnt[u]   = '0;
      end else begin
        if (m_valid[u] && hz && !flush && m_cnt[u] != m_max[u])
          m_cnt[u] = m_cnt[u] + 1;
        if (flush) begin
          m_valid[u] = 1'b0;
        end else if (e.allow) begin
          m_valid[u] = fs_v;
          if (fs_v) begin
            m_inst[u] = fs_inst;
            m_pc[u]   = fs_pc;
          end
        end
      end
    end
  endtask

  task automatic chk(input int u, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s at %0t: got %h, expected %h",
               u, nm, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        exp_t e;
        if ((u == 0 ? q0.size() : q1.size()) > 0) begin
          if (u == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk(u, "ds_valid", 32'(a_valid[u]), 32'(e.valid));
          chk(u, "ds_allowin", 32'(a_allow[u]), 32'(e.allow));
          chk(u, "ds_to_es_valid", 32'(a_toes[u]), 32'(e.toes));
          chk(u, "stall_cnt", a_cnt[u], e.cnt);
          if (e.toes) begin
            chk(u, "ds_inst", a_inst[u], e.inst);
            chk(u, "ds_pc", a_pc[u], e.pc);
            chk(u, "rs_value", a_rs[u], e.rs);
            chk(u, "rt_value", a_rt[u], e.rt);
          end
        end
      end
    end
  end

  initial begin
    regs[0] = '0;
    for (int k = 1; k < 32; k++) regs[k] = $urandom;
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 1'b0;
      m_inst[u]  = '0;
      m_pc[u]    = '0;
      m_cnt[u]   = '0;
    end
    m_max[0] = 32'd3;
    m_max[1] = 32'hFFFF_FFFF;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      reset      = (c < 2) || ($urandom % 150 == 0);
      fs_v       = ($urandom % 4) != 0;
      fs_inst    = make_inst();
      fs_pc      = $urandom;
      es_allowin = ($urandom % 4) != 0;
      flush      = ($urandom % 25) == 0;
      for (int i = 0; i < NS; i++) begin
        p_valid[i]         = ($urandom % 4) != 0;
        p_we[i]            = ($urandom % 4) != 0;
        p_rdy[i]           = ($urandom % 3) != 0;
        p_waddr[5*i +: 5]  = 5'($urandom % 8);
        p_wdata[32*i +: 32] = $urandom;
      end
      regs[$urandom_range(1, 31)] = $urandom;
      #1;
      model_step();
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk(0, "scoreboard_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ds_operand_stage.md
# ds_operand_stage

Parametrised decode-stage operand unit: the next-generation ID front half. It latches the fetched instruction and PC, reads the register file, and resolves RAW hazards against `NSTAGE` downstream producer stages. With `FWD_EN=1` it resolves them by bypassing; with `FWD_EN=0` it resolves them by stall-only interlock. It delivers `rs`/`rt` operand values to the decoder/branch logic and the EX handshake, and it keeps a saturating hazard-stall counter for performance analysis.

## Interface
Parameters:
- `DATA_W`, 32, register/operand width
- `NSTAGE`, 3, number of producer stages; index 0 is youngest (ES), then MS, then WS
- `FWD_EN`, 1, 1 = bypass network enabled, 0 = stall on any match
- `CNT_W`, 32, stall-counter width

Ports:
- `clk` in 1 clock
- `reset` in 1 reset, synchronous, active-high
- `fs_to_ds_valid` in 1 fetch stage has an instruction
- `fs_inst` in 32 fetched instruction
- `fs_pc` in 32 fetched PC
- `ds_allowin` out 1 stage can accept
- `es_allowin` in 1 EX can accept
- `ds_flush` in 1 discard the held instruction (exception/redirect)
- `ds_valid` out 1 stage holds a live instruction
- `ds_to_es_valid` out 1 instruction and operands ready to hand off
- `ds_inst` out 32 held instruction
- `ds_pc` out 32 held PC
- `rf_raddr1` out 5 register-file read address = `rs`
- `rf_raddr2` out 5 register-file read address = `rt`
- `rf_rdata1` in DATA_W register-file read data for `rs`
- `rf_rdata2` in DATA_W register-file read data for `rt`
- `prod_valid` in NSTAGE producer stage valid
- `prod_we` in NSTAGE producer writes a GPR
- `prod_waddr` in 5*NSTAGE destination register, packed, stage i at [5i+4:5i]
- `prod_wdata` in DATA_W*NSTAGE producer result, packed
- `prod_rdy` in NSTAGE result available this cycle; 0 for a load not yet returned
- `rs_value` out DATA_W resolved `rs` operand
- `rt_value` out DATA_W resolved `rt` operand
- `stall_cnt` out CNT_W saturating count of hazard-stall cycles

## Operation
- **Operand-need decode.** The sub-module decodes `need_rs`/`need_rt` from `ds_inst`:
  - `need_rs`: addu, subu, slt, sltu, and, or, xor, nor, addiu, lw, sw, beq, bne, jr.
  - `need_rt`: addu, subu, slt, sltu, and, or, xor, nor, sll, srl, sra, sw, beq, bne.
  - Unknown encodings need neither operand.
- **Per-operand match.** For operand `r` ∈ {rs, rt}: `match_i = need_r && r!=0 && prod_valid[i] && prod_we[i] && prod_waddr_i==r`.
- **Winner selection.** The winner is the lowest index `i` with `match_i`. Older matches are ignored; the youngest write is architecturally current.
- **`FWD_EN=1`.**
  - Winner exists and `prod_rdy[winner]`: the value is `prod_wdata_winner`, no stall.
  - Winner exists and not ready: operand stalls.
  - No winner: the value is `rf_rdata`.
- **`FWD_EN=0`.** Any match stalls; the value is always `rf_rdata`.
- **Stall and handshake.**
  - `hazard` = rs stall OR rt stall.
  - `ds_ready_go = !hazard`.
  - `ds_to_es_valid = ds_valid && ds_ready_go && !ds_flush`.
  - `ds_allowin = !ds_valid || (ds_ready_go && es_allowin)`.
- **Register `$0`.** It never matches. If `rs=0` the value is `rf_rdata1`, which the regfile returns as 0.
- **Stall counter.** `stall_cnt` increments each cycle in which `ds_valid && hazard`. It saturates at all-ones and holds there.

## Timing
- **Reset values.** `ds_valid`=0, `ds_inst`=0, `ds_pc`=0, `stall_cnt`=0. `ds_to_es_valid`=0 and `ds_allowin`=1 during and after reset.
- **Capture.** At the clock edge with `ds_allowin`:
  - `ds_valid <= fs_to_ds_valid && !ds_flush`.
  - Inst/PC are captured only when `fs_to_ds_valid`.
- **Flush.** `ds_flush` takes priority over capture: `ds_valid` is 0 the next cycle, and the counter does not count the flushed cycle.
- **Latency.** Operands are combinational from the held instruction and the same-cycle producer bus. Capture to handoff is 1 cycle with no hazard.
- **Stall-then-ready.**
  - A stall holds inst/PC stable.
  - The cycle `prod_rdy` rises (or the producer leaves the match), `ds_to_es_valid` asserts in that same cycle.
- **Both operands.** When both need a stall, the counter still adds 1 per cycle.
- **Counter.** It updates on the edge following the counted cycle.
- **Reset mid-stall.** Reset discards the instruction and clears the counter.

## Structure
- **Shared package (mycpu.h).**
  - Opcode/func constants.
  - `REG_ADDR_W` = 5.
  - Producer-bus field offsets.
- **Sub-module `src_need_decode`.** Combinational: `inst` → {`need_rs`, `need_rt`}.
- **Top-level contents.**
  - Pipeline register.
  - A generate-loop priority mux per operand.
  - Handshake.
  - Counter.

## Test plan
1. **Forward from ES.** `FWD_EN=1`, held `addu $3,$1,$2`, ES writes `$1`=0x11 rdy=1, rf returns 0xFF → `rs_value`=0x11, `ds_to_es_valid`=1, `stall_cnt` unchanged.
2. **Youngest wins.** ES and WS both write `$2` (0xA, 0xB), both rdy → `rt_value`=0xA.
3. **Load-use.** `lw` in ES writes `$4` with rdy=0 for 1 cycle; held `sw $4,0($5)` → 1 stall cycle, then handoff in the cycle rdy=1 with `rt_value`=load data; `stall_cnt`=1.
4. **Interlock mode.** `FWD_EN=0`, MS writes `$7` rdy=1, held `beq $7,$0` → stall until MS clears; `rs_value`=`rf_rdata1` at release.
5. **`$0` and not-needed.** `sll $3,$2,4` with ES writing `$0` and an ES match on the `rs` field → no stall, operands from rf.
6. **Counter edge cases.** `CNT_W=2`, 5 stall cycles → `stall_cnt`=3. Flush during a stall → `ds_valid`=0 next cycle, no handoff. Reset → counter 0.
